// File: rtl/clock_gate_controller_pkg.sv
// Shared definitions for the NPU clock-gate controller: FSM state encoding,
// statistics width and the registered output bundle.
package clock_gate_controller_pkg;

    typedef enum logic [1:0] {
        CG_ST_RUN   = 2'd0,
        CG_ST_GATED = 2'd1,
        CG_ST_WAKE  = 2'd2
    } cg_state_e;

    localparam int CG_STAT_W = 32;

    typedef struct packed {
        logic cg_enable;
        logic wake_ack;
        logic gated;
    } cg_out_t;

    localparam cg_out_t CG_OUT_RESET = '{cg_enable: 1'b1, wake_ack: 1'b0, gated: 1'b0};

endpackage

// File: rtl/clock_gate_stats.sv
// Gating statistics: RUN->GATED event count (wrapping) and gated-cycle count
// (saturating). Only instantiated when CLOCK_GATE_STATS_EN is defined.
module clock_gate_stats
    import clock_gate_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gate_event,
    input  logic                 gated,
    output logic [CG_STAT_W-1:0] gate_events,
    output logic [CG_STAT_W-1:0] gated_cycles
);

    localparam logic [CG_STAT_W-1:0] STAT_ONE = CG_STAT_W'(1);

    logic [CG_STAT_W-1:0] gate_events_d, gate_events_q;
    logic [CG_STAT_W-1:0] gated_cycles_d, gated_cycles_q;

    always_comb begin
        gate_events_d  = gate_events_q;
        gated_cycles_d = gated_cycles_q;
        if (gate_event) begin
            gate_events_d = gate_events_q + STAT_ONE;
        end
        // Saturate rather than wrap so a long gated stretch never reads as short.
        if (gated && (gated_cycles_q != '1)) begin
            gated_cycles_d = gated_cycles_q + STAT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_events_q  <= '0;
            gated_cycles_q <= '0;
        end else begin
            gate_events_q  <= gate_events_d;
            gated_cycles_q <= gated_cycles_d;
        end
    end

    assign gate_events  = gate_events_q;
    assign gated_cycles = gated_cycles_q;

endmodule

// File: rtl/clock_gate_controller.sv
// Always-on idle/wake controller driving the NPU clock-gating cell enables.
// Optional statistics outputs are present when CLOCK_GATE_STATS_EN is defined.
module clock_gate_controller
    import clock_gate_controller_pkg::*;
#(
    parameter int IDLE_THRESHOLD = 16,
    parameter int WAKE_LATENCY   = 2,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 activity,
    input  logic                 wake_req,
    input  logic                 force_on,
    output logic                 cg_enable,
    output logic                 wake_ack,
    output logic                 gated
`ifdef CLOCK_GATE_STATS_EN
    ,
    output logic [CG_STAT_W-1:0] gate_events,
    output logic [CG_STAT_W-1:0] gated_cycles
`endif
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_THRESHOLD - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    cg_state_e        state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    cg_out_t          out_d, out_q;
    logic             keep_awake;

    assign keep_awake = activity | wake_req | force_on;

    // NOTE: every signal gets its default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        out_d.wake_ack = 1'b0;

        unique case (state_q)
            CG_ST_RUN: begin
                if (keep_awake) begin
                    cnt_d = '0;
                    // A request already answered last edge is not acknowledged twice.
                    out_d.wake_ack = wake_req & ~out_q.wake_ack;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = CG_ST_GATED;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            CG_ST_GATED: begin
                cnt_d = '0;
                if (keep_awake) begin
                    state_d = CG_ST_WAKE;
                end
            end

            CG_ST_WAKE: begin
                if (cnt_q == WAKE_LAST) begin
                    state_d        = CG_ST_RUN;
                    cnt_d          = '0;
                    out_d.wake_ack = wake_req;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = CG_ST_RUN;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the same edge.
        out_d.cg_enable = (state_d != CG_ST_GATED);
        out_d.gated     = (state_d == CG_ST_GATED);
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CG_ST_RUN;
            cnt_q   <= '0;
            out_q   <= CG_OUT_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign cg_enable = out_q.cg_enable;
    assign wake_ack  = out_q.wake_ack;
    assign gated     = out_q.gated;

`ifdef CLOCK_GATE_STATS_EN
    logic gate_event;

    assign gate_event = (state_q == CG_ST_RUN) && (state_d == CG_ST_GATED);

    clock_gate_stats u_stats (
        .clk          (clk),
        .rst          (rst),
        .gate_event   (gate_event),
        .gated        (out_q.gated),
        .gate_events  (gate_events),
        .gated_cycles (gated_cycles)
    );
`endif

endmodule

// File: tb/tb_clock_gate_controller.sv
// Self-checking bench for clock_gate_controller: directed scenarios plus
// randomized traffic compared against an event-level reference model.
module tb_clock_gate_controller;

    localparam int TH = 4;
    localparam int WL = 2;

    logic clk = 1'b0;
    logic rst;
    logic activity, wake_req, force_on;
    logic cg_enable, wake_ack, gated;
`ifdef CLOCK_GATE_STATS_EN
    logic [31:0] gate_events, gated_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode flags plus plain counters of elapsed cycles.
    bit          m_gated, m_waking, m_ack;
    int          m_idle, m_wake_cycles;
    logic [31:0] m_gev, m_gcyc;

    clock_gate_controller #(
        .IDLE_THRESHOLD (TH),
        .WAKE_LATENCY   (WL),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .activity  (activity),
        .wake_req  (wake_req),
        .force_on  (force_on),
        .cg_enable (cg_enable),
        .wake_ack  (wake_ack),
        .gated     (gated)
`ifdef CLOCK_GATE_STATS_EN
        ,
        .gate_events  (gate_events),
        .gated_cycles (gated_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gated       = 0;
        m_waking      = 0;
        m_ack         = 0;
        m_idle        = 0;
        m_wake_cycles = 0;
        m_gev         = '0;
        m_gcyc        = '0;
    endtask

    task automatic model_edge(input bit a, input bit w, input bit f);
        bit was_gated;
        was_gated = m_gated;
        m_ack     = 0;
        if (m_waking) begin
            m_wake_cycles++;
            if (m_wake_cycles == WL) begin
                m_waking = 0;
                m_idle   = 0;
                m_ack    = w;
            end
        end else if (m_gated) begin
            if (a || w || f) begin
                m_gated       = 0;
                m_waking      = 1;
                m_wake_cycles = 0;
            end
        end else if (a || w || f) begin
            m_idle = 0;
            m_ack  = w;
        end else begin
            m_idle++;
            if (m_idle == TH) begin
                m_gated = 1;
                m_idle  = 0;
                m_gev++;
            end
        end
        if (was_gated && (m_gcyc != '1)) m_gcyc++;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".cg_enable"}, 32'(cg_enable), 32'(!m_gated));
        check({tag, ".gated"},     32'(gated),     32'(m_gated));
        check({tag, ".wake_ack"},  32'(wake_ack),  32'(m_ack));
`ifdef CLOCK_GATE_STATS_EN
        check({tag, ".gate_events"},  gate_events,  m_gev);
        check({tag, ".gated_cycles"}, gated_cycles, m_gcyc);
`endif
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, compare at the next negedge.
    task automatic step(input string tag, input bit a, input bit w, input bit f);
        activity = a;
        wake_req = w;
        force_on = f;
        model_edge(a, w, f);
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset();
        activity = 0;
        wake_req = 0;
        force_on = 0;
        rst      = 1;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    // Asynchronous reset landing between edges; outputs must react before the next edge.
    task automatic async_reset(input string tag);
        activity = 0;
        wake_req = 0;
        force_on = 0;
        @(posedge clk);
        #2 rst = 1;
        #1;
        check({tag, ".cg_enable"}, 32'(cg_enable), 32'd1);
        check({tag, ".gated"},     32'(gated),     32'd0);
        check({tag, ".wake_ack"},  32'(wake_ack),  32'd0);
`ifdef CLOCK_GATE_STATS_EN
        check({tag, ".gate_events"},  gate_events,  32'd0);
        check({tag, ".gated_cycles"}, gated_cycles, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        bit req_hold;
        int cool;
        bit a, f;

        rst      = 1;
        activity = 0;
        wake_req = 0;
        force_on = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst = 0;

        // Idle entry: gate exactly at the TH-th idle edge.
        for (int i = 1; i <= TH; i++) begin
            step("idle_entry", 0, 0, 0);
            if (i == TH - 1) check("idle_edge_before", 32'(cg_enable), 32'd1);
        end
        check("idle_edge_gate", 32'(gated), 32'd1);

        // Wake from GATED via wake_req: ack exactly WL edges after the first sample.
        step("wake_n", 0, 1, 0);
        check("wake_n_enable", 32'(cg_enable), 32'd1);
        for (int i = 1; i <= WL; i++) begin
            step("wake_lat", 0, 1, 0);
            check("wake_ack_timing", 32'(wake_ack), (i == WL) ? 32'd1 : 32'd0);
        end
        step("wake_drop", 0, 0, 0);
        check("wake_ack_single", 32'(wake_ack), 32'd0);

        // Activity at edge 3 restarts the idle run.
        do_reset();
        step("act_e1", 0, 0, 0);
        step("act_e2", 0, 0, 0);
        step("act_e3", 1, 0, 0);
        for (int i = 4; i <= 6; i++) step("act_tail", 0, 0, 0);
        check("act_edge6_enable", 32'(cg_enable), 32'd1);

        // Wake request while running: immediate ack, idle counter cleared.
        step("run_req", 0, 1, 0);
        check("run_req_ack", 32'(wake_ack), 32'd1);
        for (int i = 0; i < TH + 1; i++) step("run_after_req", 0, 0, 0);

        // force_on from GATED, then held for 100 idle cycles.
        step("force_gated", 0, 0, 1);
        for (int i = 0; i < 100; i++) step("force_hold", 0, 0, 1);
        check("force_hold_enable", 32'(cg_enable), 32'd1);
        step("force_release", 0, 0, 0);

        // Reset in the middle of WAKE.
        do_reset();
        for (int i = 0; i < TH; i++) step("pre_wake", 0, 0, 0);
        step("enter_wake", 0, 1, 0);
        async_reset("rst_mid_wake");
        wake_req = 0;
        step("post_rst", 0, 0, 0);

        // Three gate/wake rounds of exactly 10 gated cycles each.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < TH + 9; i++) step("round_idle", 0, 0, 0);
            step("round_wake", 1, 0, 0);
            for (int i = 0; i < WL; i++) step("round_run", 1, 0, 0);
        end
`ifdef CLOCK_GATE_STATS_EN
        check("stats_gate_events", gate_events, 32'd3);
        check("stats_gated_cycles", gated_cycles, 32'd30);
`endif
        check("rounds_enable", 32'(cg_enable), 32'd1);

        // Reset in the middle of GATED.
        for (int i = 0; i < TH + 2; i++) step("pre_gated_rst", 0, 0, 0);
        async_reset("rst_mid_gated");

        // Randomized traffic with a well-behaved requester.
        req_hold = 0;
        cool     = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (req_hold && wake_ack) begin
                req_hold = 0;
                cool     = 1 + int'($urandom_range(0, 6));
            end else if (!req_hold) begin
                if (cool > 0) cool--;
                else if ($urandom_range(0, 15) == 0) req_hold = 1;
            end
            if (((cyc / 40) % 2) == 1) a = ($urandom_range(0, 19) == 0);
            else a = ($urandom_range(0, 1) == 0);
            f = ($urandom_range(0, 31) == 0);
            step("random", a, req_hold, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
